bram_write_controller: RTL and testbench

//   Receive-side counterpart of the BRAM-to-UART readout path.

---
 rtl/bram_write_controller.sv | 112 +++++++++++
 tb/tb_bram_write_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_write_controller.sv
// Writes received UART bytes sequentially into BRAM port A (addresses 0..DEPTH-1)
// and pulses write_done after the last one. Optional XOR checksum: BWC_CHECKSUM_EN.
module bram_write_controller #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              write_done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0] dina_reg, dina_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      dina_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dina_reg  <= dina_next;
    end
  end

  // A byte arriving during a non-final WRITE is latched straight into the
  // write-data register, which serves as the one-deep hold stage: it is
  // written on the very next cycle, so it can never be overrun.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dina_next  = dina_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (rx_ready) begin
          dina_next  = rx_data;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_reg == LAST_ADDR) begin
          // Clearing here makes addra read 0 again from DONE onward.
          cnt_next   = '0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (rx_ready) begin
            dina_next  = rx_data;
            state_next = S_WRITE;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ena        = (state_reg == S_WRITE);
  assign wea        = (state_reg == S_WRITE);
  assign addra      = cnt_reg[ADDR_W-1:0];
  assign dina       = dina_reg;
  assign busy       = (state_reg == S_WAIT) || (state_reg == S_WRITE);
  assign write_done = (state_reg == S_DONE);

`ifdef BWC_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      checksum_reg <= '0;
    end else if (state_reg == S_WRITE) begin
      checksum_reg <= checksum_reg ^ dina_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bram_write_controller.sv
// Self-checking bench: full 1024-byte loads on one instance, table-driven
// DEPTH=4 loads (latency, back-to-back, checksum) on a second instance.
module tb_bram_write_controller;

  localparam int D = 1024;

`ifdef BWC_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with DEPTH=1024
  logic       start = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       ena, wea, busy, write_done;
  logic [9:0] addra;
  logic [7:0] dina, checksum;

  bram_write_controller #(.DEPTH(D), .ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_ready(rx_ready),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .busy(busy),
    .write_done(write_done), .checksum(checksum)
  );

  // Instance with DEPTH=4
  logic       start4 = 1'b0, rx_ready4 = 1'b0;
  logic [7:0] rx_data4 = '0;
  logic       ena4, wea4, busy4, write_done4;
  logic [1:0] addra4;
  logic [7:0] dina4, checksum4;

  bram_write_controller #(.DEPTH(4), .ADDR_W(2), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rx_data(rx_data4), .rx_ready(rx_ready4),
    .ena(ena4), .wea(wea4), .addra(addra4), .dina(dina4), .busy(busy4),
    .write_done(write_done4), .checksum(checksum4)
  );

  int total = 0, bad = 0;
  int done_cnt = 0, done_cnt4 = 0;
  logic [7:0] exp_ck = '0, exp_ck4 = '0;
  logic [7:0] mem [0:D-1];
  bit prev_last = 1'b0, prev_last4 = 1'b0;

  typedef struct packed {logic [9:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [1:0] a; logic [7:0] d;} wr4_t;
  wr_t  q[$];
  wr4_t q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitors: every BRAM write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (wea) begin
      check("ena_with_wea", 64'(ena), 64'd1);
      if (q.size() == 0) check("write_expected", 64'(q.size()), 64'd1);
      else begin
        e = q.pop_front();
        check("wr_addr", 64'(addra), 64'(e.a));
        check("wr_data", 64'(dina), 64'(e.d));
      end
      mem[addra] = dina;
    end
    if (write_done) begin
      done_cnt++;
      check("done_after_last_write", 64'(prev_last), 64'd1);
      check("checksum_at_done", 64'(checksum), CK_EN ? 64'(exp_ck) : 64'd0);
    end
    prev_last = wea && (addra == 10'(D - 1));
  end

  always @(negedge clk) begin
    wr4_t e;
    if (wea4) begin
      check("ena4_with_wea4", 64'(ena4), 64'd1);
      if (q4.size() == 0) check("write4_expected", 64'(q4.size()), 64'd1);
      else begin
        e = q4.pop_front();
        check("wr4_addr", 64'(addra4), 64'(e.a));
        check("wr4_data", 64'(dina4), 64'(e.d));
      end
    end
    if (write_done4) begin
      done_cnt4++;
      check("done4_after_last_write", 64'(prev_last4), 64'd1);
      check("checksum4_at_done", 64'(checksum4), CK_EN ? 64'(exp_ck4) : 64'd0);
    end
    prev_last4 = wea4 && (addra4 == 2'd3);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    q.push_back({10'(a), d});
    exp_ck = exp_ck ^ d;
  endtask

  task automatic push4(input int a, input logic [7:0] d);
    q4.push_back({2'(a), d});
    exp_ck4 = exp_ck4 ^ d;
  endtask

  task automatic drive(input logic [7:0] d);
    rx_data = d; rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic drive4(input logic [7:0] d);
    rx_data4 = d; rx_ready4 = 1'b1;
    tick(1);
    rx_ready4 = 1'b0;
  endtask

  typedef struct {logic [7:0] d; int gap;} vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'h01, 0}; tbl[1] = '{8'h02, 2}; tbl[2] = '{8'h04, 0}; tbl[3] = '{8'h08, 4};
    tbl[4] = '{8'hA5, 3}; tbl[5] = '{8'h3C, 0}; tbl[6] = '{8'h5A, 0}; tbl[7] = '{8'h81, 4};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_ena", 64'(ena), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_addra", 64'(addra), 64'd0);
    check("rst_dina", 64'(dina), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_write_done", 64'(write_done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);

    // DEPTH=4 loads from the table
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) begin
        exp_ck4 = '0;
        start4 = 1'b1; tick(1); start4 = 1'b0;
      end
      push4(i % 4, tbl[i].d);
      if (i == 4) begin
        check("lat_no_write_before", 64'(wea4), 64'd0);
        drive4(tbl[i].d);
        check("lat_ena", 64'(ena4), 64'd1);
        check("lat_wea", 64'(wea4), 64'd1);
        check("lat_addra", 64'(addra4), 64'd0);
        check("lat_dina", 64'(dina4), 64'hA5);
        tick(1);
        check("lat_single_write", 64'(wea4), 64'd0);
        tick(tbl[i].gap - 1);
      end else begin
        drive4(tbl[i].d);
        tick(tbl[i].gap);
      end
      if (i % 4 == 3) begin
        tick(3);
        check("d4_done_count", 64'(done_cnt4), 64'(i / 4 + 1));
        check("d4_queue_drained", 64'(q4.size()), 64'd0);
        check("d4_checksum_stable", 64'(checksum4), CK_EN ? 64'(exp_ck4) : 64'd0);
        check("d4_busy_idle", 64'(busy4), 64'd0);
        check("d4_addra_zero", 64'(addra4), 64'd0);
      end
    end

    // Load 1: byte in IDLE dropped, back-to-back bytes, then reset after 500 writes
    drive(8'hFF);
    tick(2);
    exp_ck = '0;
    start = 1'b1; tick(1); start = 1'b0;
    check("busy_in_wait", 64'(busy), 64'd1);
    push(0, 8'h01); drive(8'h01);
    push(1, 8'h11); drive(8'h11);
    push(2, 8'h22); drive(8'h22);
    tick(2);
    for (int k = 3; k < 500; k++) begin
      push(k, 8'(k));
      drive(8'(k));
      tick(2);
    end
    tick(3);
    check("load1_drained", 64'(q.size()), 64'd0);
    rst = 1'b1; rx_data = 8'h77; rx_ready = 1'b1;
    tick(1);
    rst = 1'b0; rx_ready = 1'b0;
    check("idle_after_rst_busy", 64'(busy), 64'd0);
    check("idle_after_rst_addra", 64'(addra), 64'd0);
    tick(3);
    check("no_done_after_abort", 64'(done_cnt), 64'd0);

    // Load 2: full 1024 bytes, extra bytes on final write and in DONE dropped
    exp_ck = '0;
    start = 1'b1; tick(1); start = 1'b0;
    for (int k = 0; k < D; k++) begin
      push(k, 8'(k));
      drive(8'(k));
      if (k == D - 1) begin
        drive(8'hEE);
        drive(8'hDD);
      end else begin
        tick((k % 64 == 0) ? 0 : 15);
      end
    end
    tick(3);
    check("load2_done_count", 64'(done_cnt), 64'd1);
    check("load2_drained", 64'(q.size()), 64'd0);
    check("load2_busy_idle", 64'(busy), 64'd0);
    check("load2_addra_zero", 64'(addra), 64'd0);
    check("load2_checksum_stable", 64'(checksum), CK_EN ? 64'(exp_ck) : 64'd0);
    for (int k = 0; k < D; k++) begin
      check("bram_contents", 64'(mem[k]), 64'(k % 256));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
